rs232_tx_arbiter: RTL

Shares one RS232 byte transmitter among N requesters (console, logger, error trap, ...), with round-robin fairness. Each requester can lock the grant for a multi-byte message. The block sits between the requesters and the transmitter's start/data/rdy interface. It sequences each byte so that a start is never issued while the transmitter is busy, and it never releases the channel in the middle of a locked message unless the hold timeout fires.

---
 rtl/rs232_tx_arbiter_if.sv | 24 ++
 rtl/rs232_tx_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rs232_tx_arbiter_if.sv
// rtl/rs232_tx_arbiter_if.sv - requester and transmitter signal bundle for rs232_tx_arbiter
interface rs232_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [8*N-1:0] data;
  logic [N-1:0]   ack;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_rdy;

  modport master (
    output req, lock, data, tx_rdy,
    input  ack, gnt, busy, tx_start, tx_data
  );

  modport slave (
    input  req, lock, data, tx_rdy,
    output ack, gnt, busy, tx_start, tx_data
  );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// rtl/rs232_tx_arbiter.sv - round-robin arbiter sharing one RS232 byte transmitter among N requesters
// Owners may lock the channel across bytes; an idle lock is dropped after HOLD_MAX cycles.
module rs232_tx_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 4096
) (
  input  logic              clk,
  input  logic              rst,
  rs232_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, GUARD, WAIT, HOLD} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW:0]    pick_sum;
  logic [IW-1:0]  pick;
  logic           found;
  logic           release_now;

  // Rotate req so bit 0 is the pointer position; the lowest set bit is the winner.
  always_comb begin
    req_dbl  = {bus.req, bus.req} >> ptr_q;
    req_rot  = req_dbl[N-1:0];
    found    = |req_rot;
    pick_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_sum = (IW+1)'(k);
    end
    pick_sum = pick_sum + {1'b0, ptr_q};
    if (pick_sum >= (IW+1)'(N)) pick_sum = pick_sum - (IW+1)'(N);
    pick = pick_sum[IW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!bus.req[owner_q]) begin
          release_now = 1'b1;
        end else if (bus.tx_rdy) begin
          tx_data_d  = bus.data[{owner_q, 3'b000} +: 8];
          tx_start_d = 1'b1;
          ack_d      = {{(N-1){1'b0}}, 1'b1} << owner_q;
          state_d    = GUARD;
        end
      end
      // Transmitter drops tx_rdy one cycle after start; skip that stale high.
      GUARD: state_d = WAIT;
      WAIT: begin
        if (bus.tx_rdy) begin
          if (bus.lock[owner_q] && bus.req[owner_q]) begin
            state_d = LOAD;
          end else if (bus.lock[owner_q]) begin
            hold_d  = '0;
            state_d = HOLD;
          end else begin
            release_now = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.req[owner_q]) begin
          state_d = LOAD;
        end else if (!bus.lock[owner_q] || hold_q == CW'(HOLD_MAX - 1)) begin
          release_now = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_now) begin
      gnt_d   = '0;
      ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
      state_d = IDLE;
    end
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_q     <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
endmodule
